// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   mdu_state_t     : state encoding of the multiply/divide busy FSM
//   REG_ZERO        : architectural register $0 (hard-wired zero)
//   DEF_MDU_LATENCY : default MDU busy time in cycles after a start pulse
package mips_pkg;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam int unsigned DEF_MDU_LATENCY = 4;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk   : rising-edge clock
//   i_clr   : synchronous clear, wins over i_inc
//   i_inc   : add one at this edge (ignored once the count is all ones)
//   o_count : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core (beside ID).
// Detects load-use hazards, HI/LO / mult-div hazards against the fixed-latency
// MDU, and taken branches/jumps; drives PC and IF/ID enables and flushes.
//   clk, reset        : system clock, synchronous active-high reset
//   ID_rs, ID_rt      : source fields of the ID instruction; ID_UsesRt qualifies rt
//   IDtoEX_MemRead    : EX instruction is a load; IDtoEX_RegDest its destination
//   ID_BranchTaken    : branch in ID resolved taken; ID_Jump : j/jal/jr in ID
//   ID_MulDiv         : mult/div in ID; ID_UsesHiLo : mfhi/mflo/mthi/mtlo in ID
//   PC_Write          : PC update enable; IFtoID_Write : IF/ID enable
//   IFtoID_Flush      : zero IF/ID; IDtoEX_Flush : bubble into ID/EX
//   mdu_start         : one-cycle MDU launch; mdu_busy : MDU in flight
//   stall_count       : saturating count of stall cycles
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = DEF_MDU_LATENCY,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             IDtoEX_MemRead,
  input  logic [4:0]       IDtoEX_RegDest,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             ID_MulDiv,
  input  logic             ID_UsesHiLo,
  output logic             PC_Write,
  output logic             IFtoID_Write,
  output logic             IFtoID_Flush,
  output logic             IDtoEX_Flush,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0] LAT = 4'(MDU_LATENCY);

  mdu_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic w_busy;
  logic w_lu;
  logic w_mh;
  logic w_stall;

  assign w_busy = (r_state == MDU_BUSY);

  assign w_lu = IDtoEX_MemRead && (IDtoEX_RegDest != REG_ZERO) &&
                ((IDtoEX_RegDest == ID_rs) ||
                 (ID_UsesRt && (IDtoEX_RegDest == ID_rt)));

  assign w_mh    = w_busy && (ID_MulDiv || ID_UsesHiLo);
  assign w_stall = w_lu || w_mh;

  // Control outputs are purely combinational so a stall blocks the same cycle.
  // A stalled branch/jump is not flushed; it stays in ID and is re-evaluated.
  always_comb begin
    PC_Write     = 1'b1;
    IFtoID_Write = 1'b1;
    IFtoID_Flush = ID_BranchTaken || ID_Jump;
    IDtoEX_Flush = 1'b0;
    mdu_start    = ID_MulDiv;
    mdu_busy     = w_busy;
    if (reset) begin
      PC_Write     = 1'b0;
      IFtoID_Write = 1'b0;
      IFtoID_Flush = 1'b1;
      IDtoEX_Flush = 1'b1;
      mdu_start    = 1'b0;
      mdu_busy     = 1'b0;
    end else if (w_stall) begin
      PC_Write     = 1'b0;
      IFtoID_Write = 1'b0;
      IFtoID_Flush = 1'b0;
      IDtoEX_Flush = 1'b1;
      mdu_start    = 1'b0;
    end
  end

  // MDU busy FSM: cnt loads the latency on start and counts down; leaving
  // BUSY on cnt==1 gives exactly MDU_LATENCY busy cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      MDU_IDLE: begin
        if (mdu_start) begin
          w_state_nxt = MDU_BUSY;
          w_cnt_nxt   = LAT;
        end
      end
      MDU_BUSY: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = MDU_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = MDU_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_clr   (reset),
    .i_inc   (w_stall),
    .o_count (stall_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, IDtoEX_RegDest;
  logic        ID_UsesRt, IDtoEX_MemRead, ID_BranchTaken, ID_Jump;
  logic        ID_MulDiv, ID_UsesHiLo;

  logic        PC_Write, IFtoID_Write, IFtoID_Flush, IDtoEX_Flush;
  logic        mdu_start, mdu_busy;
  logic [15:0] stall_count;

  logic        s_PC_Write, s_IFtoID_Write, s_IFtoID_Flush, s_IDtoEX_Flush;
  logic        s_mdu_start, s_mdu_busy;
  logic [2:0]  s_stall_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .IDtoEX_MemRead(IDtoEX_MemRead), .IDtoEX_RegDest(IDtoEX_RegDest),
    .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump), .ID_MulDiv(ID_MulDiv),
    .ID_UsesHiLo(ID_UsesHiLo), .PC_Write(PC_Write), .IFtoID_Write(IFtoID_Write),
    .IFtoID_Flush(IFtoID_Flush), .IDtoEX_Flush(IDtoEX_Flush), .mdu_start(mdu_start),
    .mdu_busy(mdu_busy), .stall_count(stall_count)
  );

  hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .IDtoEX_MemRead(IDtoEX_MemRead), .IDtoEX_RegDest(IDtoEX_RegDest),
    .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump), .ID_MulDiv(ID_MulDiv),
    .ID_UsesHiLo(ID_UsesHiLo), .PC_Write(s_PC_Write), .IFtoID_Write(s_IFtoID_Write),
    .IFtoID_Flush(s_IFtoID_Flush), .IDtoEX_Flush(s_IDtoEX_Flush), .mdu_start(s_mdu_start),
    .mdu_busy(s_mdu_busy), .stall_count(s_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs change #1 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0;
    IDtoEX_MemRead = 1'b0; IDtoEX_RegDest = 5'd0;
    ID_BranchTaken = 1'b0; ID_Jump = 1'b0;
    ID_MulDiv = 1'b0; ID_UsesHiLo = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    // Reset-forced outputs
    check("rst_pcw",    32'(PC_Write), 0);
    check("rst_ifw",    32'(IFtoID_Write), 0);
    check("rst_iff",    32'(IFtoID_Flush), 1);
    check("rst_idf",    32'(IDtoEX_Flush), 1);
    check("rst_start",  32'(mdu_start), 0);
    check("rst_busy",   32'(mdu_busy), 0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_cnt",    32'(stall_count), 0);
    check("idle_pcw",   32'(PC_Write), 1);

    // 1. load-use on rs
    IDtoEX_MemRead = 1'b1; IDtoEX_RegDest = 5'd8; ID_rs = 5'd8;
    #1;
    check("lu_pcw",     32'(PC_Write), 0);
    check("lu_ifw",     32'(IFtoID_Write), 0);
    check("lu_idf",     32'(IDtoEX_Flush), 1);
    tick();
    IDtoEX_MemRead = 1'b0; IDtoEX_RegDest = 5'd0;
    #1;
    check("lu_done_pcw", 32'(PC_Write), 1);
    check("lu_done_idf", 32'(IDtoEX_Flush), 0);
    check("lu_cnt",      32'(stall_count), 1);

    // 2. load to $0 never stalls
    IDtoEX_MemRead = 1'b1; IDtoEX_RegDest = 5'd0; ID_rs = 5'd0;
    #1;
    check("r0_pcw",     32'(PC_Write), 1);
    tick();
    check("r0_cnt",     32'(stall_count), 1);

    // rt match ignored when rt is not a source
    IDtoEX_RegDest = 5'd9; ID_rs = 5'd3; ID_rt = 5'd9; ID_UsesRt = 1'b0;
    #1;
    check("rt_unused_pcw", 32'(PC_Write), 1);

    // 3. taken branch during load-use on rt
    ID_UsesRt = 1'b1; ID_BranchTaken = 1'b1;
    #1;
    check("br_lu_iff",  32'(IFtoID_Flush), 0);
    check("br_lu_pcw",  32'(PC_Write), 0);
    tick();
    IDtoEX_MemRead = 1'b0;
    #1;
    check("br_iff",     32'(IFtoID_Flush), 1);
    check("br_pcw",     32'(PC_Write), 1);
    check("br_cnt",     32'(stall_count), 2);
    tick();
    idle_inputs();

    // 4. mult then mfhi stalled for the MDU latency
    ID_MulDiv = 1'b1;
    #1;
    check("mul_start",  32'(mdu_start), 1);
    check("mul_busy0",  32'(mdu_busy), 0);
    tick();
    ID_MulDiv = 1'b0; ID_UsesHiLo = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("mdu_busy_c%0d", i), 32'(mdu_busy), 1);
      check($sformatf("mfhi_pcw_c%0d", i), 32'(PC_Write), 0);
      check($sformatf("mfhi_start_c%0d", i), 32'(mdu_start), 0);
      tick();
    end
    #1;
    check("c5_busy",    32'(mdu_busy), 0);
    check("c5_pcw",     32'(PC_Write), 1);
    check("c5_cnt",     32'(stall_count), 6);
    // Back-to-back mult on the first idle cycle issues immediately
    ID_UsesHiLo = 1'b0; ID_MulDiv = 1'b1;
    #1;
    check("b2b_start",  32'(mdu_start), 1);
    check("b2b_pcw",    32'(PC_Write), 1);
    tick();
    ID_MulDiv = 1'b0;
    #1;
    check("b2b_busy1",  32'(mdu_busy), 1);
    tick();

    // 5. reset on busy cycle 2
    ID_UsesHiLo = 1'b1;
    reset = 1'b1;
    #1;
    check("rstb_busy",  32'(mdu_busy), 0);
    check("rstb_iff",   32'(IFtoID_Flush), 1);
    check("rstb_pcw",   32'(PC_Write), 0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_busy", 32'(mdu_busy), 0);
    check("post_rst_pcw",  32'(PC_Write), 1);
    check("post_rst_cnt",  32'(stall_count), 0);
    check("post_rst_cnt3", 32'(s_stall_count), 0);
    tick();
    idle_inputs();

    // 6. saturation of a 3-bit counter
    IDtoEX_MemRead = 1'b1; IDtoEX_RegDest = 5'd8; ID_rs = 5'd8;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("sat3_c%0d", i), 32'(s_stall_count), (i < 7) ? i : 7);
    end
    check("sat16_cnt", 32'(stall_count), 10);
    idle_inputs();
    tick();
    check("sat3_hold", 32'(s_stall_count), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
